// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the data-memory access unit: access-size encodings,
// FSM states, the default ack timeout, and request decode helpers.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } fun3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic request_ok(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
        fun3_t f;
        logic  legal;
        logic  aligned;
        f = fun3_t'(f3);
        case (f)
            F3_B:    begin legal = 1'b1;      aligned = 1'b1;        end
            F3_H:    begin legal = 1'b1;      aligned = ~lo[0];      end
            F3_W:    begin legal = 1'b1;      aligned = (lo == 2'b00); end
            F3_BU:   begin legal = ~is_store; aligned = 1'b1;        end
            F3_HU:   begin legal = ~is_store; aligned = ~lo[0];      end
            default: begin legal = 1'b0;      aligned = 1'b0;        end
        endcase
        return legal & aligned;
    endfunction

    function automatic logic [3:0] store_byteenable(input logic [2:0] f3, input logic [1:0] lo);
        fun3_t f;
        f = fun3_t'(f3);
        case (f)
            F3_B:    return 4'b0001 << lo;
            F3_H:    return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_writedata(input logic [2:0] f3, input logic [31:0] sd);
        fun3_t f;
        f = fun3_t'(f3);
        case (f)
            F3_B:    return {4{sd[7:0]}};
            F3_H:    return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data-cache bus between the memory access unit (master) and the cache (slave).
interface mem_access_unit_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_ack;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata, mem_byteenable,
        input  mem_readdata, mem_ack
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata, mem_byteenable,
        output mem_readdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Picks the addressed byte/halfword out of a cache word and sign- or zero-extends it.
module load_formatter
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  fun_3,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    fun3_t       f;

    always_comb begin
        f = fun3_t'(fun_3);
        case (lane)
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        half_sel = lane[1] ? readdata[31:16] : readdata[15:0];
        case (f)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'b0, byte_sel};
            F3_HU:   data = {16'b0, half_sel};
            default: data = readdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: validates requests, holds the cache request until ack or
// timeout, formats load results, and stalls the pipeline while the access is in flight.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_mem_r,
    input  logic        d_mem_w,
    input  logic [2:0]  fun_3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busywait,
    output logic [31:0] load_data,
    output logic        mem_error,
    mem_access_unit_if.master mem
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state;
    state_t             next_state;
    logic               rd_q;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic [2:0]         fun3_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        fmt_data;
    logic               req;
    logic               req_ok;
    logic               timeout;

    assign req     = d_mem_r | d_mem_w;
    assign req_ok  = req & request_ok(d_mem_w, fun_3, address[1:0]);
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    load_formatter u_load_formatter (
        .readdata (mem.mem_readdata),
        .lane     (addr_q[1:0]),
        .fun_3    (fun3_q),
        .data     (fmt_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A request's read/write, address, lanes and data are captured once in IDLE and replayed
    // unchanged for the whole access; store wins over load when both are raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            fun3_q    <= '0;
            cnt       <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_ok) begin
                        rd_q    <= d_mem_r & ~d_mem_w;
                        wr_q    <= d_mem_w;
                        addr_q  <= address;
                        fun3_q  <= fun_3;
                        be_q    <= d_mem_w ? store_byteenable(fun_3, address[1:0]) : 4'b1111;
                        wdata_q <= d_mem_w ? store_writedata(fun_3, store_data) : '0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (mem.mem_ack && rd_q) load_data <= fmt_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = req_ok ? ACCESS : DONE;
            ACCESS:  if (mem.mem_ack || timeout) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are gated by reset so an in-flight request is dropped the instant reset rises.
    always_comb begin
        busywait      = 1'b0;
        mem_error     = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    busywait  = req_ok;
                    mem_error = req & ~req_ok;
                end
                ACCESS: begin
                    busywait      = 1'b1;
                    mem.mem_read  = rd_q;
                    mem.mem_write = wr_q;
                    mem_error     = timeout & ~mem.mem_ack;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_address    = {addr_q[31:2], 2'b00};
    assign mem.mem_writedata  = wdata_q;
    assign mem.mem_byteenable = be_q;
endmodule
